// File: rtl/seg_pkg.sv
// Shared seven-segment definitions used by both the frame decoder and the
// segment encoder side.
//   - segment patterns (bit0=a .. bit6=g, active-high, dp excluded)
//   - 3-bit digit codes, with CODE_BAD for unrecognised patterns
//   - frame decoder FSM state encoding
package seg_pkg;

    localparam int unsigned CODE_W = 3;

    localparam logic [6:0] PAT_0 = 7'h3F;
    localparam logic [6:0] PAT_1 = 7'h06;
    localparam logic [6:0] PAT_2 = 7'h5B;
    localparam logic [6:0] PAT_3 = 7'h4F;
    localparam logic [6:0] PAT_4 = 7'h66;
    localparam logic [6:0] PAT_E = 7'h79;

    localparam logic [CODE_W-1:0] CODE_0   = 3'd0;
    localparam logic [CODE_W-1:0] CODE_1   = 3'd1;
    localparam logic [CODE_W-1:0] CODE_2   = 3'd2;
    localparam logic [CODE_W-1:0] CODE_3   = 3'd3;
    localparam logic [CODE_W-1:0] CODE_4   = 3'd4;
    localparam logic [CODE_W-1:0] CODE_E   = 3'd5;
    localparam logic [CODE_W-1:0] CODE_BAD = 3'd7;

    localparam logic STATE_COLLECT = 1'b0;
    localparam logic STATE_PRESENT = 1'b1;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to digit-code decoder.
//   seg  : observed segments a..g (dp not included)
//   code : digit code, CODE_BAD when the pattern is not recognised
//   bad  : high when the pattern is not recognised
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0]        seg,
    output logic [CODE_W-1:0] code,
    output logic              bad
);

    always_comb begin
        code = CODE_BAD;
        bad  = 1'b1;
        case (seg)
            PAT_0: begin code = CODE_0; bad = 1'b0; end
            PAT_1: begin code = CODE_1; bad = 1'b0; end
            PAT_2: begin code = CODE_2; bad = 1'b0; end
            PAT_3: begin code = CODE_3; bad = 1'b0; end
            PAT_4: begin code = CODE_4; bad = 1'b0; end
            PAT_E: begin code = CODE_E; bad = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/seg_frame_decoder.sv
// Recovers a frame of digit codes by observing a multiplexed seven-segment
// display bus. Each digit is captured once its (dig_sel, segments) sample has
// been stable for STABLE_CYCLES edges; a full frame is then presented with a
// valid/ready handshake.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   seg_in     : observed segments, bit0=a .. bit6=g, bit7=dp (ignored)
//   dig_sel    : observed one-hot digit enable
//   out_ready  : consumer accepts the presented frame
//   out_valid  : frame held on frame_data
//   frame_data : digit i code at [3i+2:3i]
//   frame_bad  : at least one digit of the frame was unrecognised
module seg_frame_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned NUM_DIGITS    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   seg_in,
    input  logic [NUM_DIGITS-1:0]        dig_sel,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [CODE_W*NUM_DIGITS-1:0] frame_data,
    output logic                         frame_bad
);

    localparam logic [3:0] STABLE = STABLE_CYCLES[3:0];

    logic                         state_q, state_d;
    logic [NUM_DIGITS-1:0]        sel_q;
    logic [6:0]                   seg_q;
    logic [3:0]                   cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]        mask_q, mask_d;
    logic                         bad_q, bad_d;
    logic [CODE_W*NUM_DIGITS-1:0] frame_q, frame_d;

    logic              sel_onehot;
    logic              same;
    logic              capture;
    logic [CODE_W-1:0] dec_code;
    logic              dec_bad;
    logic              unused_dp;

    assign unused_dp = seg_in[7];

    seg_pattern_decode u_decode (
        .seg  (seg_in[6:0]),
        .code (dec_code),
        .bad  (dec_bad)
    );

    assign sel_onehot = $onehot(dig_sel);
    assign same       = (dig_sel == sel_q) && (seg_in[6:0] == seg_q);

    // Capture only on the edge that reaches STABLE, so a held sample fires once
    // and a period already saturated when PRESENT exits never fires.
    assign capture = (state_q == STATE_COLLECT) && sel_onehot && same
                     && (cnt_q == STABLE - 4'd1);

    always_comb begin
        if (sel_onehot && same) begin
            cnt_d = (cnt_q >= STABLE) ? STABLE : cnt_q + 4'd1;
        end else begin
            cnt_d = sel_onehot ? 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        bad_d   = bad_q;
        frame_d = frame_q;

        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (capture && dig_sel[i]) begin
                frame_d[CODE_W*i +: CODE_W] = dec_code;
                mask_d[i]                   = 1'b1;
            end
        end
        if (capture) begin
            bad_d = bad_q | dec_bad;
        end

        if (state_q == STATE_COLLECT) begin
            // Mask is checked as registered: out_valid follows the completing
            // capture by one cycle.
            if (&mask_q) begin
                state_d = STATE_PRESENT;
            end
        end else if (out_ready) begin
            state_d = STATE_COLLECT;
            mask_d  = '0;
            bad_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_COLLECT;
            sel_q   <= '0;
            seg_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            bad_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= dig_sel;
            seg_q   <= seg_in[6:0];
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            bad_q   <= bad_d;
            frame_q <= frame_d;
        end
    end

    assign out_valid  = (state_q == STATE_PRESENT);
    assign frame_data = frame_q;
    assign frame_bad  = bad_q;

endmodule

// File: doc/seg_frame_decoder.md
SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive identical samples required before a digit is accepted (legal range 2..15).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed digit positions per frame.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 seg_in  input  8  observed segment pattern, active-high, bit0=a .. bit6=g, bit7=dp.
REQ-006 dig_sel  input  NUM_DIGITS  observed digit enable, active-high, one-hot when valid.
REQ-007 out_ready  input  1  consumer accepts the frame.
REQ-008 out_valid  output  1  a complete frame is held on frame_data.
REQ-009 frame_data  output  3*NUM_DIGITS  decoded digit codes; digit i occupies bits [3i+2:3i].
REQ-010 frame_bad  output  1  at least one digit in the frame had an unrecognised pattern.

Function
REQ-011 Pattern decode, bit7 ignored: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x79->5 (error glyph "E"). Any other pattern -> code 7, bad flag set.
REQ-012 The sample is (dig_sel, seg_in[6:0]). A stability counter counts consecutive edges with an identical sample and one-hot dig_sel. It saturates at STABLE_CYCLES.
REQ-013 Sample change, or dig_sel zero or non-one-hot: counter reloads to 1 if the new dig_sel is one-hot, else to 0. No capture occurs on that edge.
REQ-014 Capture happens on the edge where the counter reaches STABLE_CYCLES. It writes the decoded code into the selected slot, sets that slot's bit in the captured mask, and ORs the bad flag into a sticky bad register.
REQ-015 Capture occurs exactly once per stable period. A held sample does not re-capture until the sample changes.
REQ-016 Re-capture of an already-captured slot before the frame completes overwrites that slot's code. The sticky bad register is not cleared by the overwrite.
REQ-017 FSM states:
  - COLLECT: captures enabled.
  - PRESENT: out_valid=1; captures inhibited, but the stability counter keeps running.
REQ-018 COLLECT->PRESENT on the edge after the captured mask becomes all-ones. frame_data and frame_bad are then stable through PRESENT.
REQ-019 PRESENT->COLLECT on the first edge with out_valid&&out_ready. That edge also clears the captured mask and the sticky bad register.
REQ-020 Latency: out_valid rises 1 cycle after the capture that completes the mask.
REQ-021 out_valid, frame_data and frame_bad do not change while out_valid=1 && out_ready=0.
REQ-022 out_ready is ignored in COLLECT.
REQ-023 A stable period already at STABLE_CYCLES when PRESENT exits does not capture. Only a new stable period captures.

Reset
REQ-024 rst_n low, asynchronous, forces:
  - state=COLLECT
  - out_valid=0, frame_data=0, frame_bad=0
  - captured mask=0, sticky bad=0
  - stability counter=0, sample registers=0
REQ-025 Reset mid-frame or mid-PRESENT discards the partial or pending frame. The first frame after release requires fresh captures of all slots.

Structure
REQ-026 Pattern constants (0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x79), code constants (0..5, 7) and the FSM state encoding SHALL live in shared package seg_pkg, reused by the segment encoder side.
REQ-027 Pattern-to-code decode SHALL be the combinational sub-module seg_pattern_decode: in seg[6:0], out code[2:0] and bad.

Verification (STABLE_CYCLES=4, NUM_DIGITS=4)
REQ-028 Scan digits 0..3 showing 0x06, 0x5B, 0x4F, 0x66, each held 6 cycles, out_ready=1. Required: out_valid pulses 1 cycle, frame_data=12'b100_011_010_001, frame_bad=0.
REQ-029 Hold digit 2 with 0x79 for exactly 3 cycles, then change. Required: no capture. Then hold 4 cycles. Required: slot 2 code 5, frame_bad=0 at completion.
REQ-030 Digit 1 shows 0x7F. Required: slot 1 code 7, frame_bad=1. After handshake, the next clean frame has frame_bad=0.
REQ-031 Complete a frame with out_ready=0 for 10 cycles while scanning new patterns. Required: out_valid and frame_data are frozen and the new patterns are not captured. Raise out_ready, then run a new full scan. Required: a new frame is produced.
REQ-032 dig_sel=4'b0110 for 8 cycles. Required: counter stays 0, no capture. dig_sel=4'b0000 likewise.
REQ-033 Assert rst_n=0 for 1 cycle after 3 slots are captured, and again during PRESENT. Required: all outputs 0 at once, and the next frame needs 4 fresh captures.
